// File: rtl/lane_operand_requester_if.sv
// Operand-request, VRF read-port and operand-queue signals of one lane requester.
interface lane_operand_requester_if #(
    parameter int unsigned NrOpQueue    = 3,
    parameter int unsigned VRFAddrWidth = 8,
    parameter int unsigned AccCntWidth  = 7
);
    logic                                  op_req_valid_i;
    logic                                  op_req_ready_o;
    logic [10+NrOpQueue+AccCntWidth-1:0]   op_req_i;
    logic                                  vrf_rd_req_o;
    logic [VRFAddrWidth-1:0]               vrf_rd_addr_o;
    logic                                  vrf_rd_gnt_i;
    logic [63:0]                           vrf_rd_data_i;
    logic [NrOpQueue-1:0]                  op_valid_o;
    logic [NrOpQueue-1:0]                  op_ready_i;
    logic [64*NrOpQueue-1:0]               op_data_o;

    modport slave (
        input  op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, op_ready_i,
        output op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, op_valid_o, op_data_o
    );

    modport master (
        output op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, op_ready_i,
        input  op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, op_valid_o, op_data_o
    );
endinterface

// File: rtl/lane_operand_requester.sv
// Per-lane operand requester: walks the VRF slice for each requested operand queue
// and buffers the returned words in credit-checked per-queue FIFOs.
module lane_operand_requester #(
    parameter int unsigned NrOpQueue    = 3,
    parameter int unsigned QueueDepth   = 4,
    parameter int unsigned VRFAddrWidth = 8,
    parameter int unsigned AccCntWidth  = 7
) (
    input logic clk_i,
    input logic rst_i,
    lane_operand_requester_if.slave bus
);
    localparam int unsigned QIdxW = (NrOpQueue > 1) ? $clog2(NrOpQueue) : 1;
    localparam int unsigned PtrW  = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int unsigned OccW  = PtrW + 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_q, state_d;
    logic [AccCntWidth-1:0]  remaining_q [NrOpQueue];
    logic [AccCntWidth-1:0]  remaining_d [NrOpQueue];
    logic [VRFAddrWidth-1:0] addr_q [NrOpQueue];
    logic [VRFAddrWidth-1:0] addr_d [NrOpQueue];
    logic [QIdxW-1:0]        rr_q, rr_d;
    logic                    lock_q, lock_d;
    logic [QIdxW-1:0]        lock_sel_q, lock_sel_d;
    logic                    inf_vld_q, inf_vld_d;
    logic [QIdxW-1:0]        inf_sel_q, inf_sel_d;
    logic [63:0]             mem_q [NrOpQueue][QueueDepth];
    logic [63:0]             mem_d [NrOpQueue][QueueDepth];
    logic [PtrW-1:0]         wr_ptr_q [NrOpQueue];
    logic [PtrW-1:0]         wr_ptr_d [NrOpQueue];
    logic [PtrW-1:0]         rd_ptr_q [NrOpQueue];
    logic [PtrW-1:0]         rd_ptr_d [NrOpQueue];
    logic [OccW-1:0]         occ_q [NrOpQueue];
    logic [OccW-1:0]         occ_d [NrOpQueue];

    logic [NrOpQueue-1:0]    eligible, push, pop;
    logic                    sel_found, rd_gnt, any_left;
    logic [QIdxW-1:0]        sel;

    logic [4:0]              req_vs1, req_vs2;
    logic [NrOpQueue-1:0]    req_queue;
    logic [AccCntWidth-1:0]  req_acc;

    assign {req_vs1, req_vs2, req_queue, req_acc} = bus.op_req_i;

    // A queue only competes while a word slot is free counting the one in flight.
    always_comb begin
        eligible  = '0;
        sel_found = lock_q;
        sel       = lock_sel_q;
        for (int unsigned q = 0; q < NrOpQueue; q++) begin
            eligible[q] = (remaining_q[q] != '0) &&
                ((OccW+1)'(occ_q[q]) + (OccW+1)'(inf_vld_q && (32'(inf_sel_q) == q))
                 < (OccW+1)'(QueueDepth));
        end
        if (!lock_q) begin
            for (int unsigned q = 0; q < NrOpQueue; q++) begin
                if (!sel_found && eligible[q] && (q >= 32'(rr_q))) begin
                    sel_found = 1'b1;
                    sel       = QIdxW'(q);
                end
            end
            for (int unsigned q = 0; q < NrOpQueue; q++) begin
                if (!sel_found && eligible[q]) begin
                    sel_found = 1'b1;
                    sel       = QIdxW'(q);
                end
            end
        end
    end

    assign rd_gnt = sel_found && bus.vrf_rd_gnt_i;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        rr_d        = rr_q;
        lock_d      = sel_found && !bus.vrf_rd_gnt_i;
        lock_sel_d  = sel;
        inf_vld_d   = rd_gnt;
        inf_sel_d   = sel;
        any_left    = 1'b0;
        if (rd_gnt) begin
            remaining_d[sel] = remaining_q[sel] - AccCntWidth'(1);
            addr_d[sel]      = addr_q[sel] + VRFAddrWidth'(1);
            rr_d             = (32'(sel) == NrOpQueue - 1) ? '0 : sel + QIdxW'(1);
        end
        for (int unsigned q = 0; q < NrOpQueue; q++) begin
            any_left = any_left || (remaining_d[q] != '0);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.op_req_valid_i) begin
                    for (int unsigned q = 0; q < NrOpQueue; q++) begin
                        remaining_d[q] = req_queue[q] ? req_acc : '0;
                        addr_d[q]      = VRFAddrWidth'({(q == 1) ? req_vs2 : req_vs1, 3'b000});
                    end
                    if ((req_acc != '0) && (req_queue != '0)) state_d = BUSY;
                end
            end
            BUSY: begin
                if (!any_left) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        push     = '0;
        pop      = '0;
        for (int unsigned q = 0; q < NrOpQueue; q++) begin
            push[q] = inf_vld_q && (32'(inf_sel_q) == q);
            pop[q]  = bus.op_ready_i[q] && (occ_q[q] != '0);
            if (push[q]) begin
                mem_d[q][wr_ptr_q[q]] = bus.vrf_rd_data_i;
                wr_ptr_d[q]           = wr_ptr_q[q] + PtrW'(1);
            end
            if (pop[q]) rd_ptr_d[q] = rd_ptr_q[q] + PtrW'(1);
            occ_d[q] = occ_q[q] + OccW'(push[q]) - OccW'(pop[q]);
        end
    end

    always_comb begin
        bus.op_valid_o = '0;
        bus.op_data_o  = '0;
        for (int unsigned q = 0; q < NrOpQueue; q++) begin
            bus.op_valid_o[q]         = (occ_q[q] != '0);
            bus.op_data_o[64*q +: 64] = mem_q[q][rd_ptr_q[q]];
        end
    end

    assign bus.op_req_ready_o = (state_q == IDLE);
    assign bus.vrf_rd_req_o   = sel_found;
    assign bus.vrf_rd_addr_o  = sel_found ? addr_q[sel] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            inf_vld_q  <= 1'b0;
            inf_sel_q  <= '0;
            for (int unsigned q = 0; q < NrOpQueue; q++) begin
                remaining_q[q] <= '0;
                addr_q[q]      <= '0;
                wr_ptr_q[q]    <= '0;
                rd_ptr_q[q]    <= '0;
                occ_q[q]       <= '0;
                for (int unsigned e = 0; e < QueueDepth; e++) mem_q[q][e] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            lock_sel_q  <= lock_sel_d;
            inf_vld_q   <= inf_vld_d;
            inf_sel_q   <= inf_sel_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_lane_operand_requester.sv
// Randomized and directed bench for lane_operand_requester with a VRF model,
// per-queue expected-word scoreboard and an independent pop monitor.
module tb_lane_operand_requester;
    localparam int unsigned NQ = 3, DEPTH = 4, AW = 8, ACW = 7;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    lane_operand_requester_if #(.NrOpQueue(NQ), .VRFAddrWidth(AW), .AccCntWidth(ACW)) bus ();
    lane_operand_requester #(.NrOpQueue(NQ), .QueueDepth(DEPTH), .VRFAddrWidth(AW),
                             .AccCntWidth(ACW)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] vrf_mem [256];
    logic [63:0] exp_data [NQ][$];
    int unsigned exp_addr [NQ][$];
    int          outstanding [NQ];
    int          gnt_mode = 2;
    int          rdy_mode = 0;
    logic [NQ-1:0] manual_rdy = '0;
    bit          poison = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int q = 0; q < NQ; q++) begin
            exp_data[q].delete();
            exp_addr[q].delete();
            outstanding[q] = 0;
        end
    endtask

    // Leaves valid high after the handshake; the next send_req or end_req drops it.
    task automatic send_req(input logic [4:0] vs1, input logic [4:0] vs2,
                            input logic [NQ-1:0] qr, input logic [ACW-1:0] acc, output int waited);
        @(posedge clk_i); #1;
        bus.op_req_valid_i = 1'b1;
        bus.op_req_i       = {vs1, vs2, qr, acc};
        waited = 0;
        @(negedge clk_i);
        while (!bus.op_req_ready_o && waited < 300) begin
            waited++;
            @(negedge clk_i);
        end
        if (!bus.op_req_ready_o) begin
            n_checks++; n_errors++;
            $display("FAIL req_accept: got no handshake after %0d cycles, required accept", waited);
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (qr[q]) begin
                    for (int k = 0; k < int'(acc); k++) begin
                        int unsigned base, a;
                        base = (q == 1) ? 32'(vs2) : 32'(vs1);
                        a    = (base * 8 + 32'(k)) % 256;
                        exp_addr[q].push_back(a);
                        exp_data[q].push_back(vrf_mem[a]);
                    end
                end
            end
        end
    endtask

    task automatic end_req();
        @(posedge clk_i); #1;
        bus.op_req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        bit done;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 800) begin
            @(negedge clk_i);
            cyc++;
            done = bus.op_req_ready_o && !bus.vrf_rd_req_o && exp_data[0].size() == 0 &&
                   exp_data[1].size() == 0 && exp_data[2].size() == 0;
        end
        check(name, 64'(done), 64'(1));
    endtask

    initial begin : responder
        logic          pend_vld;
        logic [AW-1:0] pend_addr;
        pend_vld = 1'b0;
        pend_addr = '0;
        bus.vrf_rd_gnt_i  = 1'b0;
        bus.vrf_rd_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (pend_vld) bus.vrf_rd_data_i = poison ? 64'hDEAD_BEEF : vrf_mem[pend_addr];
            else          bus.vrf_rd_data_i = {$urandom, $urandom};
            pend_vld = 1'b0;
            case (gnt_mode)
                0:       bus.vrf_rd_gnt_i = 1'b1;
                1:       bus.vrf_rd_gnt_i = ($urandom_range(0, 3) != 0);
                default: bus.vrf_rd_gnt_i = 1'b0;
            endcase
            @(negedge clk_i);
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) begin
                pend_vld  = 1'b1;
                pend_addr = bus.vrf_rd_addr_o;
            end
        end
    end

    initial begin : ready_driver
        bus.op_ready_i = '0;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       bus.op_ready_i = '1;
                1:       bus.op_ready_i = NQ'($urandom);
                default: bus.op_ready_i = manual_rdy;
            endcase
        end
    end

    initial begin : monitor
        int hit;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) begin
                    hit = -1;
                    for (int q = 0; q < NQ; q++)
                        if (hit < 0 && exp_addr[q].size() != 0 &&
                            exp_addr[q][0] == 32'(bus.vrf_rd_addr_o)) hit = q;
                    if (hit < 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL grant_addr: got %0d required next pending address of a queue",
                                 bus.vrf_rd_addr_o);
                    end else begin
                        void'(exp_addr[hit].pop_front());
                        outstanding[hit]++;
                        check($sformatf("credit_q%0d", hit), 64'(outstanding[hit] <= DEPTH), 64'(1));
                    end
                end
                for (int q = 0; q < NQ; q++) begin
                    if (bus.op_valid_o[q] && bus.op_ready_i[q]) begin
                        if (exp_data[q].size() == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL pop_q%0d: got %0h required no word", q, bus.op_data_o[64*q +: 64]);
                        end else begin
                            check($sformatf("pop_q%0d", q), bus.op_data_o[64*q +: 64], exp_data[q].pop_front());
                            outstanding[q]--;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w, w2, cnt, bad;
        int unsigned vadd_addr [6];
        logic          req_at   [1:8];
        logic          ready_at [1:8];
        logic          val0_at  [1:8];
        logic [AW-1:0] addr_at  [1:8];
        logic [AW-1:0] first, other, ga [4];
        logic [NQ-1:0] qtab [5];
        logic [4:0]    v1;
        vadd_addr = '{16, 40, 17, 41, 18, 42};
        qtab      = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        for (int i = 0; i < 256; i++) vrf_mem[i] = {$urandom, $urandom};
        clear_model();
        rst_i = 1'b1;
        bus.op_req_valid_i = 1'b0;
        bus.op_req_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 64'(bus.op_req_ready_o), 64'(1));
        check("rst_rd_req", 64'(bus.vrf_rd_req_o), 64'(0));
        check("rst_rd_addr", 64'(bus.vrf_rd_addr_o), 64'(0));
        check("rst_op_valid", 64'(bus.op_valid_o), 64'(0));
        check("rst_op_data_or", 64'(|bus.op_data_o), 64'(0));
        @(posedge clk_i); #1 rst_i = 1'b0;

        // VADD: two queues interleaved, grant always
        gnt_mode = 0; rdy_mode = 0;
        send_req(5'd2, 5'd5, 3'b011, 7'd3, w);
        check("vadd_accept_wait", 64'(w), 64'(0));
        end_req();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            req_at[c] = bus.vrf_rd_req_o; ready_at[c] = bus.op_req_ready_o;
            val0_at[c] = bus.op_valid_o[0]; addr_at[c] = bus.vrf_rd_addr_o;
        end
        check("vadd_req_c1", 64'(req_at[1]), 64'(1));
        for (int c = 1; c <= 6; c++) check($sformatf("vadd_addr_c%0d", c), 64'(addr_at[c]), 64'(vadd_addr[c-1]));
        check("vadd_valid_c2", 64'(val0_at[2]), 64'(0));
        check("vadd_valid_c3", 64'(val0_at[3]), 64'(1));
        check("vadd_ready_c6", 64'(ready_at[6]), 64'(0));
        check("vadd_ready_c7", 64'(ready_at[7]), 64'(1));
        check("vadd_req_c7", 64'(req_at[7]), 64'(0));
        wait_idle("vadd_drain");

        // VSE: address wraps at the top of the VRF slice
        send_req(5'd31, 5'd0, 3'b100, 7'd10, w);
        end_req();
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            @(negedge clk_i);
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) begin
                check($sformatf("vse_addr_%0d", cnt), 64'(bus.vrf_rd_addr_o), 64'((248 + cnt) % 256));
                cnt++;
            end
        end
        check("vse_grants", 64'(cnt), 64'(10));
        wait_idle("vse_drain");

        // Credit: consumer stalled, only DEPTH reads may be issued
        rdy_mode = 2; manual_rdy = '0;
        send_req(5'd6, 5'd0, 3'b001, 7'd8, w);
        end_req();
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) cnt++;
        end
        check("credit_grants", 64'(cnt), 64'(DEPTH));
        check("credit_req_low", 64'(bus.vrf_rd_req_o), 64'(0));
        manual_rdy = 3'b001;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            manual_rdy = '0;
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) cnt++;
        end
        check("credit_one_more", 64'(cnt), 64'(1));
        check("credit_req_low2", 64'(bus.vrf_rd_req_o), 64'(0));
        rdy_mode = 0;
        wait_idle("credit_drain");

        // Grant withheld: chosen queue and address must not move
        gnt_mode = 2;
        send_req(5'd3, 5'd7, 3'b011, 7'd2, w);
        end_req();
        @(negedge clk_i);
        first = bus.vrf_rd_addr_o;
        check("hold_first_valid", 64'(first == 8'd24 || first == 8'd56), 64'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("hold_req", 64'(bus.vrf_rd_req_o), 64'(1));
            check("hold_addr", 64'(bus.vrf_rd_addr_o), 64'(first));
        end
        gnt_mode = 0;
        other = (first == 8'd24) ? 8'd56 : 8'd24;
        cnt = 0;
        for (int c = 0; c < 12 && cnt < 4; c++) begin
            @(negedge clk_i);
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) begin ga[cnt] = bus.vrf_rd_addr_o; cnt++; end
        end
        check("hold_grants", 64'(cnt), 64'(4));
        check("hold_g0", 64'(ga[0]), 64'(first));
        check("hold_g1", 64'(ga[1]), 64'(other));
        check("hold_g2", 64'(ga[2]), 64'(first + 8'd1));
        check("hold_g3", 64'(ga[3]), 64'(other + 8'd1));
        wait_idle("hold_drain");

        // Zero-length request completes at once
        send_req(5'd1, 5'd2, 3'b011, 7'd0, w);
        send_req(5'd4, 5'd0, 3'b001, 7'd1, w2);
        check("zero_next_accept_wait", 64'(w2), 64'(0));
        check("zero_no_read", 64'(bus.vrf_rd_req_o), 64'(0));
        end_req();
        @(negedge clk_i);
        check("zero_next_req", 64'(bus.vrf_rd_req_o), 64'(1));
        check("zero_next_addr", 64'(bus.vrf_rd_addr_o), 64'(32));
        wait_idle("zero_drain");

        // Reset mid-operation; the returning word must be dropped
        rdy_mode = 2; manual_rdy = '0;
        send_req(5'd9, 5'd0, 3'b001, 7'd6, w);
        end_req();
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 2; c++) begin
            @(negedge clk_i);
            if (bus.vrf_rd_req_o && bus.vrf_rd_gnt_i) cnt++;
        end
        check("rstmid_grants", 64'(cnt), 64'(2));
        poison = 1'b1;
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        clear_model();
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        poison = 1'b0;
        check("rstmid_valid", 64'(bus.op_valid_o), 64'(0));
        check("rstmid_ready", 64'(bus.op_req_ready_o), 64'(1));
        check("rstmid_req", 64'(bus.vrf_rd_req_o), 64'(0));
        check("rstmid_data_or", 64'(|bus.op_data_o), 64'(0));
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (bus.op_valid_o != '0) bad++;
        end
        check("rstmid_no_enqueue", 64'(bad), 64'(0));
        rdy_mode = 0;

        // Random traffic with random grant and pop
        gnt_mode = 1; rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            v1 = 5'($urandom_range(0, 31));
            send_req(v1, 5'((32'(v1) + $urandom_range(1, 31)) % 32), qtab[$urandom_range(0, 4)],
                     7'($urandom_range(0, 8)), w);
        end
        end_req();
        wait_idle("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
